// File: rtl/fp_alu_pkg.sv
// fp_alu_pkg
// Shared definitions for the floating-point ALU mantissa datapath.
//   MANT_W     : mantissa width including the hidden bit
//   ONE_Q123   : 1.0 in Q1.23, upper clamp of the reciprocal
//   HALF_Q123  : 0.5 in Q1.23, lower clamp of the reciprocal
//   TWO_Q223   : 2.0 in Q2.23, minuend of the Newton-Raphson correction term
//   nr_state_t : sequencer states of the reciprocal refinement stage
package fp_alu_pkg;

   localparam int          MANT_W    = 24;
   localparam logic [23:0] ONE_Q123  = 24'h800000;
   localparam logic [23:0] HALF_Q123 = 24'h400000;
   localparam logic [24:0] TWO_Q223  = 25'h1000000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MUL_T = 2'd1,
      MUL_X = 2'd2,
      DONE  = 2'd3
   } nr_state_t;

endpackage

// File: rtl/mantissa_nr_mul.sv
// mantissa_nr_mul
// Combinational 24x25 unsigned multiplier shared by both Newton-Raphson
// half-steps. Kept separate so it can be pipelined or mapped onto a DSP
// block without touching the sequencer.
//   a    : 24-bit unsigned operand
//   b    : 25-bit unsigned operand
//   prod : 49-bit unsigned product
module mantissa_nr_mul (
   input  logic [23:0] a,
   input  logic [24:0] b,
   output logic [48:0] prod
);

   assign prod = 49'(a) * 49'(b);

endmodule

// File: rtl/mantissa_reciprocal_nr_refine.sv
// mantissa_reciprocal_nr_refine
// Refines a low-precision reciprocal seed for a 24-bit divisor mantissa by
// ITERATIONS rounds of x <- x*(2 - d*x), using one shared multiplier.
//   ITERATIONS     : number of refinement rounds, legal range 1..3
//   clk            : clock, rising edge
//   rst            : asynchronous reset, active low
//   valid_data_in  : d/seed valid, taken only while in_ready is high
//   d              : divisor mantissa, Q1.23
//   seed           : initial reciprocal estimate, Q1.23
//   in_ready       : high while idle
//   out            : refined reciprocal, Q1.23, held between results
//   valid_data_out : one-cycle pulse marking a new out value
module mantissa_reciprocal_nr_refine
   import fp_alu_pkg::*;
#(
   parameter int ITERATIONS = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_data_in,
   input  logic [MANT_W-1:0] d,
   input  logic [MANT_W-1:0] seed,
   output logic              in_ready,
   output logic [MANT_W-1:0] out,
   output logic              valid_data_out
);

   localparam logic [1:0] LAST_CNT = 2'(ITERATIONS - 1);

   nr_state_t         state;
   nr_state_t         state_n;
   logic [MANT_W-1:0] d_r;
   logic [MANT_W-1:0] x_r;
   logic [24:0]       t_r;
   logic [1:0]        iter_cnt;
   logic [MANT_W-1:0] out_r;
   logic              valid_r;

   logic [24:0]       e_val;
   logic [24:0]       mul_b;
   logic [48:0]       prod;
   logic [MANT_W-1:0] x_trunc;
   logic [MANT_W-1:0] x_new;
   logic              last_iter;
   logic              prod_low_unused;

   // Operand mux: MUL_T forms d*x, MUL_X forms x*(2 - t). The x operand is
   // common to both half-steps, so only the second operand is switched.
   assign e_val = TWO_Q223 - t_r;
   assign mul_b = (state == MUL_X) ? e_val : {1'b0, d_r};

   mantissa_nr_mul u_mul (
      .a    (x_r),
      .b    (mul_b),
      .prod (prod)
   );

   assign prod_low_unused = ^prod[22:0];

   // Truncate the Q3.46 product back to Q1.23 and keep the estimate inside
   // [0.5, 1.0]. Any integer bit at or above 2^1 means overflow and must win
   // over the lower clamp, because the truncated field alone may look tiny.
   assign x_trunc = prod[46:23];

   always_comb begin
      x_new = x_trunc;
      if ((prod[48:47] != 2'b00) || (x_trunc > ONE_Q123)) begin
         x_new = ONE_Q123;
      end else if (x_trunc < HALF_Q123) begin
         x_new = HALF_Q123;
      end
   end

   assign last_iter = (iter_cnt == LAST_CNT);

   // Next-state decode for the IDLE -> (MUL_T -> MUL_X)* -> DONE sequence.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (valid_data_in) state_n = MUL_T;
         MUL_T:   state_n = MUL_X;
         MUL_X:   state_n = last_iter ? DONE : MUL_T;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Datapath registers. The result register and its valid pulse are loaded
   // on the edge that enters DONE, so both are visible throughout the DONE
   // cycle straight from flops and out keeps its value afterwards.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         d_r      <= '0;
         x_r      <= '0;
         t_r      <= '0;
         iter_cnt <= '0;
         out_r    <= '0;
         valid_r  <= 1'b0;
      end else begin
         state   <= state_n;
         valid_r <= 1'b0;
         case (state)
            IDLE: begin
               if (valid_data_in) begin
                  d_r      <= d;
                  x_r      <= seed;
                  iter_cnt <= '0;
               end
            end
            MUL_T: begin
               t_r <= prod[47:23];
            end
            MUL_X: begin
               x_r      <= x_new;
               iter_cnt <= iter_cnt + 2'd1;
               if (last_iter) begin
                  out_r   <= x_new;
                  valid_r <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready       = (state == IDLE);
   assign out            = out_r;
   assign valid_data_out = valid_r;

endmodule

// File: tb/tb_mantissa_reciprocal_nr_refine.sv
// tb_mantissa_reciprocal_nr_refine
// Directed bench for the Newton-Raphson reciprocal refinement stage:
// reset values, a table of hand-computed vectors (exact and clamped cases),
// a back-to-back handshake sequence, reset in the middle of an operation,
// and a batch of random divisors checked against 1/d truncated to Q1.23.
module tb_mantissa_reciprocal_nr_refine;

   localparam int ITER     = 2;
   localparam int LATENCY  = 2 * ITER + 1;
   localparam int N_RANDOM = 2000;

   logic        clk;
   logic        rst;
   logic        valid_data_in;
   logic [23:0] d_in;
   logic [23:0] seed_in;
   logic        in_ready;
   logic [23:0] out;
   logic        valid_data_out;

   int n_vectors;
   int n_checks;
   int n_fail;

   typedef struct {
      logic [23:0] d;
      logic [23:0] seed;
      logic [23:0] lo;
      logic [23:0] hi;
   } vec_t;

   vec_t vecs[8];

   mantissa_reciprocal_nr_refine #(
      .ITERATIONS (ITER)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .valid_data_in  (valid_data_in),
      .d              (d_in),
      .seed           (seed_in),
      .in_ready       (in_ready),
      .out            (out),
      .valid_data_out (valid_data_out)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something upstream of the bounded waits goes wrong.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Exact comparison of one observed value against its expected value.
   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp_v);
      end
   endtask

   // Inclusive range comparison for results that carry rounding slack.
   task automatic check_range(input string name, input logic [31:0] act,
                              input logic [31:0] lo, input logic [31:0] hi);
      n_checks++;
      if ((^act === 1'bx) || (act < lo) || (act > hi)) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h..0x%0h", name, act, lo, hi);
      end
   endtask

   // Presents one transaction at an idle negedge, then follows it through to
   // its result, checking handshake, latency, pulse width and value.
   task automatic apply_stimulus(input logic [23:0] dv, input logic [23:0] sv,
                                 input logic [23:0] lo, input logic [23:0] hi,
                                 input string tag);
      int lat;
      d_in          = dv;
      seed_in       = sv;
      valid_data_in = 1'b1;
      @(negedge clk);
      valid_data_in = 1'b0;
      n_vectors++;
      check_output({tag, " busy"}, 32'(in_ready), 32'd0);
      lat = 1;
      while ((valid_data_out !== 1'b1) && (lat < 20)) begin
         @(negedge clk);
         lat++;
      end
      check_output({tag, " latency"}, 32'(lat), 32'(LATENCY));
      check_range({tag, " out"}, 32'(out), 32'(lo), 32'(hi));
      @(negedge clk);
      check_output({tag, " pulse width"}, 32'(valid_data_out), 32'd0);
      check_output({tag, " ready again"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [23:0] hs_d[18];
      logic [23:0] hs_s[18];
      logic [23:0] exp_out;
      logic        exp_valid;
      logic        exp_rdy;
      logic [63:0] ref_q;
      logic [23:0] rd;
      logic [23:0] rs;
      logic [23:0] rref;
      int          pulses;

      n_vectors = 0;
      n_checks  = 0;
      n_fail    = 0;

      // Hand-computed vectors; lo == hi where the NR sequence lands exactly.
      vecs[0] = '{d: 24'h800000, seed: 24'h800000, lo: 24'h800000, hi: 24'h800000};
      vecs[1] = '{d: 24'hC00000, seed: 24'h555000, lo: 24'h555555, hi: 24'h555555};
      vecs[2] = '{d: 24'hFFFFFF, seed: 24'h400000, lo: 24'h400000, hi: 24'h400000};
      vecs[3] = '{d: 24'h800000, seed: 24'h400000, lo: 24'h780000, hi: 24'h780000};
      vecs[4] = '{d: 24'h400000, seed: 24'h800000, lo: 24'h800000, hi: 24'h800000};
      vecs[5] = '{d: 24'hFFFFFF, seed: 24'h200000, lo: 24'h400000, hi: 24'h400000};
      vecs[6] = '{d: 24'h000000, seed: 24'h800000, lo: 24'h800000, hi: 24'h800000};
      vecs[7] = '{d: 24'hA00000, seed: 24'h666000, lo: 24'h666666, hi: 24'h666666};

      // Reset with the clock running, then check the cleared outputs.
      rst           = 1'b0;
      valid_data_in = 1'b0;
      d_in          = '0;
      seed_in       = '0;
      repeat (3) @(negedge clk);
      check_output("reset out", 32'(out), 32'd0);
      check_output("reset valid", 32'(valid_data_out), 32'd0);
      check_output("reset ready", 32'(in_ready), 32'd1);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         apply_stimulus(vecs[i].d, vecs[i].seed, vecs[i].lo, vecs[i].hi,
                        $sformatf("vec%0d", i));
      end

      // Back-to-back handshake: valid held high with new data every cycle.
      // Only inputs 0, 6 and 12 land in IDLE; everything else must vanish.
      for (int k = 0; k < 18; k++) begin
         hs_d[k] = 24'h400000;
         hs_s[k] = 24'h800000;
      end
      hs_d[0]  = 24'hC00000; hs_s[0]  = 24'h555000;
      hs_d[6]  = 24'hA00000; hs_s[6]  = 24'h666000;
      hs_d[12] = 24'h800000; hs_s[12] = 24'h400000;
      exp_out = 24'h666666;
      for (int k = 0; k < 20; k++) begin
         if (k < 18) begin
            valid_data_in = 1'b1;
            d_in          = hs_d[k];
            seed_in       = hs_s[k];
         end else begin
            valid_data_in = 1'b0;
         end
         @(negedge clk);
         exp_valid = (k == 4) || (k == 10) || (k == 16);
         exp_rdy   = (k == 5) || (k == 11) || (k >= 17);
         if (k == 4)  exp_out = 24'h555555;
         if (k == 10) exp_out = 24'h666666;
         if (k == 16) exp_out = 24'h780000;
         check_output($sformatf("hs valid c%0d", k), 32'(valid_data_out), 32'(exp_valid));
         check_output($sformatf("hs ready c%0d", k), 32'(in_ready), 32'(exp_rdy));
         check_output($sformatf("hs out c%0d", k), 32'(out), 32'(exp_out));
      end
      n_vectors += 3;

      // Reset during MUL_X of the first round: outputs clear without a clock
      // edge, no pulse escapes, and the next transaction runs normally.
      d_in          = 24'hC00000;
      seed_in       = 24'h555000;
      valid_data_in = 1'b1;
      @(negedge clk);
      valid_data_in = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_output("midrst out", 32'(out), 32'd0);
      check_output("midrst valid", 32'(valid_data_out), 32'd0);
      check_output("midrst ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst    = 1'b1;
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (valid_data_out === 1'b1) pulses++;
      end
      check_output("midrst no pulse", 32'(pulses), 32'd0);
      apply_stimulus(24'hA00000, 24'h666000, 24'h666666, 24'h666666, "postrst");

      // Random divisors with a coarse LUT-like seed (top 9 bits of 1/d),
      // compared against 1/d truncated to Q1.23 with 2 ulp slack.
      for (int i = 0; i < N_RANDOM; i++) begin
         rd    = 24'($urandom_range(24'h7FFFFF, 0)) | 24'h800000;
         ref_q = 64'h0000_4000_0000_0000 / 64'(rd);
         rref  = ref_q[23:0];
         rs    = rref & 24'hFF8000;
         apply_stimulus(rd, rs, rref - 24'd2, rref + 24'd2, $sformatf("rnd%0d d=%h", i, rd));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_fail);
      $finish;
   end

endmodule
